// File: rtl/dst_reg_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : dst_reg_pipeline
// Brief    : Write-destination tracker for the pipelined MIPS core. Resolves
//            each instruction's GRF write address (A3) from its destination
//            mode and carries A3 plus its Tnew countdown through STAGES
//            pipeline registers (stage 0 = E ... last = W). From the in-flight
//            destinations it derives the D-stage stall request and the
//            per-operand forwarding selects.
// Ports    : clk, reset (async, active-low)
//            d_valid, d_regdst, d_rt, d_rd, d_tnew : instruction in D
//            e_cond                                : condition resolved in E
//            flush, hold                           : pipeline control
//            q_rs, q_rt, q_tuse_rs, q_tuse_rt      : D-stage source queries
//            stage_a3, stage_tnew                  : per-stage A3 / Tnew
//            stall, fwd_rs, fwd_rt                 : hazard outputs
// Revision : 1.0 - initial release
// ============================================================================
module dst_reg_pipeline #(
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,   // must be >= 2
  parameter int TNEW_W   = 2,
  parameter int LINK_REG = 31,
  parameter int FWD_W    = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     d_valid,
  input  logic [3:0]               d_regdst,
  input  logic [ADDR_W-1:0]        d_rt,
  input  logic [ADDR_W-1:0]        d_rd,
  input  logic [TNEW_W-1:0]        d_tnew,
  input  logic                     e_cond,
  input  logic                     flush,
  input  logic                     hold,
  input  logic [ADDR_W-1:0]        q_rs,
  input  logic [ADDR_W-1:0]        q_rt,
  input  logic [TNEW_W-1:0]        q_tuse_rs,
  input  logic [TNEW_W-1:0]        q_tuse_rt,
  output logic [STAGES*ADDR_W-1:0] stage_a3,
  output logic [STAGES*TNEW_W-1:0] stage_tnew,
  output logic                     stall,
  output logic [FWD_W-1:0]         fwd_rs,
  output logic [FWD_W-1:0]         fwd_rt
);

  localparam logic [ADDR_W-1:0] C_LINK   = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] C_ZERO_A = '0;
  localparam logic [3:0]        C_MODE_RT    = 4'd0;
  localparam logic [3:0]        C_MODE_RD    = 4'd1;
  localparam logic [3:0]        C_MODE_LINK  = 4'd2;
  localparam logic [3:0]        C_MODE_CLINK = 4'd3;
  localparam logic [3:0]        C_MODE_CRD   = 4'd4;
  // Any mode >= 5 resolves to $0, so a bubble is simply an unused mode.
  localparam logic [3:0]        C_MODE_NONE  = 4'hF;

  // Stage 0 keeps the raw fields because its address may depend on e_cond.
  logic [3:0]        r_mode0;
  logic [ADDR_W-1:0] r_rt0;
  logic [ADDR_W-1:0] r_rd0;
  logic [TNEW_W-1:0] r_tnew0;

  // Stages >= 1 hold already-resolved addresses.
  logic [ADDR_W-1:0] r_a3     [1:STAGES-1];
  logic [TNEW_W-1:0] r_tnew_hi[1:STAGES-1];

  logic [ADDR_W-1:0] w_res0;   // actual A3 of stage 0 (uses e_cond)
  logic [ADDR_W-1:0] w_cand0;  // conservative hazard address of stage 0

  logic [ADDR_W-1:0] w_res  [0:STAGES-1];
  logic [ADDR_W-1:0] w_cand [0:STAGES-1];
  logic [TNEW_W-1:0] w_tnew [0:STAGES-1];

  logic              w_stall;
  logic [FWD_W-1:0]  w_fwd_rs;
  logic [FWD_W-1:0]  w_fwd_rt;

  function automatic logic [TNEW_W-1:0] f_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Stage 0 address resolution. The hazard candidate ignores e_cond so that
  // stall never depends combinationally on the E-stage condition.
  // --------------------------------------------------------------------------
  always_comb begin
    w_res0  = C_ZERO_A;
    w_cand0 = C_ZERO_A;
    case (r_mode0)
      C_MODE_RT: begin
        w_res0  = r_rt0;
        w_cand0 = r_rt0;
      end
      C_MODE_RD: begin
        w_res0  = r_rd0;
        w_cand0 = r_rd0;
      end
      C_MODE_LINK: begin
        w_res0  = C_LINK;
        w_cand0 = C_LINK;
      end
      C_MODE_CLINK: begin
        w_res0  = e_cond ? C_LINK : C_ZERO_A;
        w_cand0 = C_LINK;
      end
      C_MODE_CRD: begin
        w_res0  = e_cond ? r_rd0 : C_ZERO_A;
        w_cand0 = r_rd0;
      end
      default: begin
        w_res0  = C_ZERO_A;
        w_cand0 = C_ZERO_A;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Uniform per-stage views and flattened outputs.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_view
      if (k == 0) begin : g_first
        assign w_res[k]  = w_res0;
        assign w_cand[k] = w_cand0;
        assign w_tnew[k] = r_tnew0;
      end else begin : g_rest
        assign w_res[k]  = r_a3[k];
        assign w_cand[k] = r_a3[k];
        assign w_tnew[k] = r_tnew_hi[k];
      end
      assign stage_a3[k*ADDR_W +: ADDR_W]   = w_res[k];
      assign stage_tnew[k*TNEW_W +: TNEW_W] = w_tnew[k];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stage registers. Stage 0 -> 1 latches the resolved address, so the
  // e_cond outcome is frozen at the moment the instruction leaves E.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode0 <= C_MODE_NONE;
      r_rt0   <= '0;
      r_rd0   <= '0;
      r_tnew0 <= '0;
      for (int k = 1; k < STAGES; k++) begin
        r_a3[k]      <= '0;
        r_tnew_hi[k] <= '0;
      end
    end else if (!hold) begin
      if (w_stall || flush || !d_valid) begin
        r_mode0 <= C_MODE_NONE;
        r_rt0   <= '0;
        r_rd0   <= '0;
        r_tnew0 <= '0;
      end else begin
        r_mode0 <= d_regdst;
        r_rt0   <= d_rt;
        r_rd0   <= d_rd;
        r_tnew0 <= d_tnew;
      end
      for (int k = 1; k < STAGES; k++) begin
        r_a3[k]      <= w_res[k-1];
        r_tnew_hi[k] <= f_dec(w_tnew[k-1]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall: any in-flight producer whose result arrives after the consumer's
  // Tuse. Address 0 is excluded, which also neutralises query address 0.
  // --------------------------------------------------------------------------
  always_comb begin
    w_stall = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if ((w_cand[k] != C_ZERO_A) && (w_cand[k] == q_rs) && (w_tnew[k] > q_tuse_rs))
        w_stall = 1'b1;
      if ((w_cand[k] != C_ZERO_A) && (w_cand[k] == q_rt) && (w_tnew[k] > q_tuse_rt))
        w_stall = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding: walk from the farthest stage towards stage 0 so the nearest
  // match overwrites. A nearest match that is not ready yields 0 rather than
  // falling back to an older (stale) copy.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fwd_rs = '0;
    w_fwd_rt = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if ((w_res[k] != C_ZERO_A) && (w_res[k] == q_rs))
        w_fwd_rs = (w_tnew[k] == '0) ? FWD_W'(k + 1) : '0;
      if ((w_res[k] != C_ZERO_A) && (w_res[k] == q_rt))
        w_fwd_rt = (w_tnew[k] == '0) ? FWD_W'(k + 1) : '0;
    end
  end

  assign stall  = w_stall;
  assign fwd_rs = w_fwd_rs;
  assign fwd_rt = w_fwd_rt;

endmodule
`default_nettype wire

// File: tb/tb_dst_reg_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_dst_reg_pipeline
// Brief    : Directed self-checking bench for dst_reg_pipeline (default
//            3-stage instance plus a 5-stage / 6-bit instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dst_reg_pipeline;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Default instance (ADDR_W=5, STAGES=3, TNEW_W=2)
  logic        d_valid = 0;
  logic [3:0]  d_regdst = 0;
  logic [4:0]  d_rt = 0, d_rd = 0;
  logic [1:0]  d_tnew = 0;
  logic        e_cond = 0, flush = 0, hold = 0;
  logic [4:0]  q_rs = 0, q_rt = 0;
  logic [1:0]  q_tuse_rs = 0, q_tuse_rt = 0;
  logic [14:0] stage_a3;
  logic [5:0]  stage_tnew;
  logic        stall;
  logic [1:0]  fwd_rs, fwd_rt;

  // Deep instance (ADDR_W=6, STAGES=5)
  logic        b_valid = 0;
  logic [3:0]  b_regdst = 0;
  logic [5:0]  b_rt = 0, b_rd = 0;
  logic [1:0]  b_tnew = 0;
  logic        b_cond = 0, b_flush = 0, b_hold = 0;
  logic [5:0]  b_q_rs = 0, b_q_rt = 0;
  logic [1:0]  b_tuse_rs = 0, b_tuse_rt = 0;
  logic [29:0] b_a3;
  logic [9:0]  b_tn;
  logic        b_stall;
  logic [2:0]  b_fwd_rs, b_fwd_rt;

  int checks = 0;
  int failures = 0;

  dst_reg_pipeline dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_regdst(d_regdst),
    .d_rt(d_rt), .d_rd(d_rd), .d_tnew(d_tnew), .e_cond(e_cond),
    .flush(flush), .hold(hold), .q_rs(q_rs), .q_rt(q_rt),
    .q_tuse_rs(q_tuse_rs), .q_tuse_rt(q_tuse_rt), .stage_a3(stage_a3),
    .stage_tnew(stage_tnew), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  dst_reg_pipeline #(.ADDR_W(6), .STAGES(5)) dut5 (
    .clk(clk), .reset(reset), .d_valid(b_valid), .d_regdst(b_regdst),
    .d_rt(b_rt), .d_rd(b_rd), .d_tnew(b_tnew), .e_cond(b_cond),
    .flush(b_flush), .hold(b_hold), .q_rs(b_q_rs), .q_rt(b_q_rt),
    .q_tuse_rs(b_tuse_rs), .q_tuse_rt(b_tuse_rt), .stage_a3(b_a3),
    .stage_tnew(b_tn), .stall(b_stall), .fwd_rs(b_fwd_rs), .fwd_rt(b_fwd_rt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int a3(input int k);
    return int'(stage_a3[k*5 +: 5]);
  endfunction

  function automatic int tn(input int k);
    return int'(stage_tnew[k*2 +: 2]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in D for exactly one edge, then a nop.
  task automatic issue(input logic [3:0] mode, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [1:0] tnew);
    d_valid = 1; d_regdst = mode; d_rt = rt; d_rd = rd; d_tnew = tnew;
    step();
    d_valid = 0; d_regdst = 0; d_rt = 0; d_rd = 0; d_tnew = 0;
  endtask

  task automatic drain();
    q_rs = 0; q_rt = 0; q_tuse_rs = 0; q_tuse_rt = 0; e_cond = 0;
    repeat (3) step();
  endtask

  initial begin
    // ---- reset ----
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_a3", stage_a3, 0);
    #20 reset = 1;
    step();
    chk("post_rst_stall", stall, 0);
    chk("post_rst_fwd", fwd_rs, 0);
    chk("post_rst_tnew", stage_tnew, 0);

    // ---- addu rd=8 tnew=1, consumer Tuse 0 ----
    issue(4'd1, 5'd0, 5'd8, 2'd1);
    chk("addu_a3_0", a3(0), 8);
    chk("addu_tn_0", tn(0), 1);
    q_rs = 8; q_tuse_rs = 0; #1;
    chk("addu_stall", stall, 1);
    chk("addu_fwd_e", fwd_rs, 0);
    step();
    chk("addu_a3_1", a3(1), 8);
    chk("addu_bubble", a3(0), 0);
    chk("addu_nostall", stall, 0);
    chk("addu_fwd_m", fwd_rs, 2);
    drain();

    // ---- lw rt=9 tnew=2 then dependent beq ----
    issue(4'd0, 5'd9, 5'd0, 2'd2);
    d_valid = 1; d_regdst = 4'd5; q_rs = 9; q_tuse_rs = 0; #1;
    chk("lw_stall1", stall, 1);
    step();
    chk("lw_bubble", a3(0), 0);
    chk("lw_tn_1", tn(1), 1);
    chk("lw_stall2", stall, 1);
    step();
    chk("lw_stall3", stall, 0);
    chk("lw_fwd_w", fwd_rs, 3);
    d_valid = 0; d_regdst = 0;
    drain();

    // ---- conditional link, e_cond=0 ----
    issue(4'd3, 5'd0, 5'd0, 2'd1);
    q_rs = 31; q_tuse_rs = 0; #1;
    chk("clink0_a3_0", a3(0), 0);
    chk("clink0_stall", stall, 1);
    step();
    chk("clink0_a3_1", a3(1), 0);
    chk("clink0_fwd", fwd_rs, 0);
    chk("clink0_nostall", stall, 0);
    drain();

    // ---- conditional link, e_cond=1 ----
    issue(4'd3, 5'd0, 5'd0, 2'd1);
    e_cond = 1; q_rs = 31; q_tuse_rs = 0; #1;
    chk("clink1_a3_0", a3(0), 31);
    chk("clink1_stall", stall, 1);
    step();
    chk("clink1_a3_1", a3(1), 31);
    chk("clink1_fwd", fwd_rs, 2);
    drain();

    // ---- write to $0 ----
    issue(4'd0, 5'd0, 5'd0, 2'd2);
    q_rs = 0; q_rt = 0; #1;
    chk("zero_stall", stall, 0);
    chk("zero_fwd", fwd_rs, 0);
    step();
    chk("zero_stall2", stall, 0);
    chk("zero_fwd2", fwd_rt, 0);
    drain();

    // ---- flush: instruction replaced by bubble ----
    d_valid = 1; d_regdst = 4'd1; d_rd = 5'd7; d_tnew = 2'd1; flush = 1;
    step();
    flush = 0; d_valid = 0; d_regdst = 0; d_rd = 0; d_tnew = 0;
    chk("flush_a3_0", a3(0), 0);
    drain();

    // ---- duplicate reg 5 in stage 0 (tnew 1) and stage 2 (tnew 0) ----
    issue(4'd1, 5'd0, 5'd5, 2'd1);
    step();
    issue(4'd1, 5'd0, 5'd5, 2'd1);
    chk("dup_a3_2", a3(2), 5);
    chk("dup_tn_2", tn(2), 0);
    q_rs = 5; q_tuse_rs = 1; #1;
    chk("dup_stall", stall, 0);
    chk("dup_fwd", fwd_rs, 0);

    // ---- hold for 3 cycles: everything frozen (stage2 5, stage1 0, stage0 5) ----
    hold = 1;
    d_valid = 1; d_regdst = 4'd1; d_rd = 5'd12; d_tnew = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_a3", stage_a3, (5 << 10) | 5);
      chk("hold_tnew", stage_tnew, 1);
      chk("hold_fwd", fwd_rs, 0);
    end
    hold = 0; d_valid = 0; d_regdst = 0; d_rd = 0; d_tnew = 0;
    step();
    chk("unhold_fwd", fwd_rs, 2);

    // ---- asynchronous reset mid-pipeline ----
    #2 reset = 0;
    #1;
    chk("arst_a3", stage_a3, 0);
    chk("arst_fwd", fwd_rs, 0);
    chk("arst_stall", stall, 0);
    #10 reset = 1;
    q_rs = 0; q_tuse_rs = 0;
    step();

    // ---- 5-stage instance: rd=40 walks through all slots ----
    b_valid = 1; b_regdst = 4'd1; b_rd = 6'd40; b_tnew = 2'd0;
    step();
    b_valid = 0; b_regdst = 0; b_rd = 0;
    b_q_rs = 40; #1;
    for (int k = 0; k < 5; k++) begin
      chk("deep_a3", int'(b_a3[k*6 +: 6]), 40);
      chk("deep_fwd", b_fwd_rs, k + 1);
      step();
    end
    chk("deep_gone", b_fwd_rs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
